// File: rtl/alu_branch_pc.sv
// Execute / fetch-control slice of the single-cycle MIPS core: main ALU, branch
// resolution, next-PC selection and the PC, HI, LO and active state registers.
module alu_branch_pc (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clk_enable_i,
    input  logic [5:0]  opcode_i,
    input  logic [5:0]  functcode_i,
    input  logic [4:0]  shamt_i,
    input  logic [4:0]  rt_field_i,
    input  logic [15:0] immediate_i,
    input  logic [25:0] instr_index_i,
    input  logic [31:0] rs_content_i,
    input  logic [31:0] rt_content_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] branch_address_o,
    output logic [31:0] alu_result_o,
    output logic        sig_branch_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        active_o
);

    localparam logic [31:0] RESET_VEC = 32'hBFC0_0000;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LWL    = 6'h22;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_LWR    = 6'h26;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    // REGIMM rt_field selectors
    localparam logic [4:0] RI_BLTZ   = 5'h00;
    localparam logic [4:0] RI_BGEZ   = 5'h01;
    localparam logic [4:0] RI_BLTZAL = 5'h10;
    localparam logic [4:0] RI_BGEZAL = 5'h11;

    typedef struct packed {
        logic        we_hi;
        logic        we_lo;
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_wr_t;

    logic [31:0] pc_q, pc_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        active_q;

    logic [31:0] rs, rt;
    logic [31:0] pc_plus4, pc_plus8, branch_address;
    logic [31:0] imm_sext, imm_zext;
    logic [31:0] sum_rs_imm;
    logic        rs_neg, rs_zero;

    logic [31:0] sra_shamt, sra_rs;
    logic [63:0] mul_s, mul_u;
    logic [31:0] rs_mag, rt_mag, sdiv_den, udiv_den;
    logic [31:0] uq_mag, ur_mag, sdiv_q, sdiv_r, udiv_q, udiv_r;
    logic        div_by_zero;

    logic [31:0] alu_result;
    logic        sig_branch;
    logic        is_jump_reg, is_jump_abs;
    hilo_wr_t    hl_wr;

    assign rs = rs_content_i;
    assign rt = rt_content_i;

    assign pc_plus4       = pc_q + 32'd4;
    assign pc_plus8       = pc_q + 32'd8;
    assign imm_sext       = {{16{immediate_i[15]}}, immediate_i};
    assign imm_zext       = {16'h0000, immediate_i};
    assign branch_address = pc_plus4 + {imm_sext[29:0], 2'b00};
    assign sum_rs_imm     = rs + imm_sext;
    assign rs_neg         = rs[31];
    assign rs_zero        = (rs == 32'd0);

    assign sra_shamt = $signed(rt) >>> shamt_i;
    assign sra_rs    = $signed(rt) >>> rs[4:0];

    assign mul_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    assign mul_u = {32'd0, rs} * {32'd0, rt};

    // Signed division on magnitudes keeps truncation toward zero explicit and
    // makes 0x80000000 / -1 wrap to 0x80000000 with no special case.
    assign div_by_zero = (rt == 32'd0);
    assign rs_mag      = rs[31] ? (32'd0 - rs) : rs;
    assign rt_mag      = rt[31] ? (32'd0 - rt) : rt;
    assign sdiv_den    = div_by_zero ? 32'd1 : rt_mag;
    assign udiv_den    = div_by_zero ? 32'd1 : rt;
    assign uq_mag      = rs_mag / sdiv_den;
    assign ur_mag      = rs_mag % sdiv_den;
    assign sdiv_q      = (rs[31] ^ rt[31]) ? (32'd0 - uq_mag) : uq_mag;
    assign sdiv_r      = rs[31] ? (32'd0 - ur_mag) : ur_mag;
    assign udiv_q      = rs / udiv_den;
    assign udiv_r      = rs % udiv_den;

    always_comb begin
        alu_result  = 32'd0;
        sig_branch  = 1'b0;
        is_jump_reg = 1'b0;
        is_jump_abs = 1'b0;
        hl_wr       = '0;
        unique case (opcode_i)
            OP_RTYPE: begin
                unique case (functcode_i)
                    FN_SLL:   alu_result = rt << shamt_i;
                    FN_SRL:   alu_result = rt >> shamt_i;
                    FN_SRA:   alu_result = sra_shamt;
                    FN_SLLV:  alu_result = rt << rs[4:0];
                    FN_SRLV:  alu_result = rt >> rs[4:0];
                    FN_SRAV:  alu_result = sra_rs;
                    FN_JR:    is_jump_reg = 1'b1;
                    FN_JALR: begin
                        is_jump_reg = 1'b1;
                        alu_result  = pc_plus8;
                    end
                    FN_MFHI:  alu_result = hi_q;
                    FN_MFLO:  alu_result = lo_q;
                    FN_MTHI: begin
                        hl_wr.we_hi = 1'b1;
                        hl_wr.hi    = rs;
                    end
                    FN_MTLO: begin
                        hl_wr.we_lo = 1'b1;
                        hl_wr.lo    = rs;
                    end
                    FN_MULT:  hl_wr = '{1'b1, 1'b1, mul_s[63:32], mul_s[31:0]};
                    FN_MULTU: hl_wr = '{1'b1, 1'b1, mul_u[63:32], mul_u[31:0]};
                    FN_DIV: begin
                        if (!div_by_zero) hl_wr = '{1'b1, 1'b1, sdiv_r, sdiv_q};
                    end
                    FN_DIVU: begin
                        if (!div_by_zero) hl_wr = '{1'b1, 1'b1, udiv_r, udiv_q};
                    end
                    FN_ADD, FN_ADDU: alu_result = rs + rt;
                    FN_SUB, FN_SUBU: alu_result = rs - rt;
                    FN_AND:   alu_result = rs & rt;
                    FN_OR:    alu_result = rs | rt;
                    FN_XOR:   alu_result = rs ^ rt;
                    FN_NOR:   alu_result = ~(rs | rt);
                    FN_SLT:   alu_result = {31'd0, $signed(rs) < $signed(rt)};
                    FN_SLTU:  alu_result = {31'd0, rs < rt};
                    default:  alu_result = 32'd0;
                endcase
            end
            OP_REGIMM: begin
                unique case (rt_field_i)
                    RI_BLTZ:   sig_branch = rs_neg;
                    RI_BGEZ:   sig_branch = !rs_neg;
                    RI_BLTZAL: begin
                        sig_branch = rs_neg;
                        alu_result = pc_plus8;
                    end
                    RI_BGEZAL: begin
                        sig_branch = !rs_neg;
                        alu_result = pc_plus8;
                    end
                    default:   sig_branch = 1'b0;
                endcase
            end
            OP_J:     is_jump_abs = 1'b1;
            OP_JAL: begin
                is_jump_abs = 1'b1;
                alu_result  = pc_plus8;
            end
            OP_BEQ:   sig_branch = (rs == rt);
            OP_BNE:   sig_branch = (rs != rt);
            OP_BLEZ:  sig_branch = rs_neg || rs_zero;
            OP_BGTZ:  sig_branch = !rs_neg && !rs_zero;
            OP_ADDI, OP_ADDIU: alu_result = sum_rs_imm;
            OP_SLTI:  alu_result = {31'd0, $signed(rs) < $signed(imm_sext)};
            OP_SLTIU: alu_result = {31'd0, rs < imm_sext};
            OP_ANDI:  alu_result = rs & imm_zext;
            OP_ORI:   alu_result = rs | imm_zext;
            OP_XORI:  alu_result = rs ^ imm_zext;
            OP_LUI:   alu_result = {immediate_i, 16'h0000};
            OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
            OP_SB, OP_SH, OP_SW: alu_result = sum_rs_imm;
            default:  alu_result = 32'd0;
        endcase
    end

    // No delay slot: register jumps beat absolute jumps, which beat branches.
    always_comb begin
        pc_d = pc_plus4;
        if (is_jump_reg)      pc_d = rs;
        else if (is_jump_abs) pc_d = {pc_plus4[31:28], instr_index_i, 2'b00};
        else if (sig_branch)  pc_d = branch_address;
    end

    assign hi_d = hl_wr.we_hi ? hl_wr.hi : hi_q;
    assign lo_d = hl_wr.we_lo ? hl_wr.lo : lo_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pc_q     <= RESET_VEC;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            active_q <= 1'b1;
        end else if (clk_enable_i && active_q) begin
            pc_q <= pc_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            if (pc_d == 32'd0) active_q <= 1'b0;
        end
    end

    assign pc_o             = pc_q;
    assign pc_plus4_o       = pc_plus4;
    assign branch_address_o = branch_address;
    assign alu_result_o     = alu_result;
    assign sig_branch_o     = sig_branch;
    assign hi_o             = hi_q;
    assign lo_o             = lo_q;
    assign active_o         = active_q;

endmodule

// File: tb/tb_alu_branch_pc.sv
// Bench for alu_branch_pc: directed scenarios plus random instructions, with
// expectations from an arithmetic reference model queued to a negedge monitor.
module tb_alu_branch_pc;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        clk_enable_i;
    logic [5:0]  opcode_i, functcode_i;
    logic [4:0]  shamt_i, rt_field_i;
    logic [15:0] immediate_i;
    logic [25:0] instr_index_i;
    logic [31:0] rs_content_i, rt_content_i;
    logic [31:0] pc_o, pc_plus4_o, branch_address_o, alu_result_o, hi_o, lo_o;
    logic        sig_branch_o, active_o;

    alu_branch_pc dut (
        .clk_i(clk_i), .reset_i(reset_i), .clk_enable_i(clk_enable_i),
        .opcode_i(opcode_i), .functcode_i(functcode_i), .shamt_i(shamt_i),
        .rt_field_i(rt_field_i), .immediate_i(immediate_i), .instr_index_i(instr_index_i),
        .rs_content_i(rs_content_i), .rt_content_i(rt_content_i),
        .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .branch_address_o(branch_address_o),
        .alu_result_o(alu_result_o), .sig_branch_o(sig_branch_o),
        .hi_o(hi_o), .lo_o(lo_o), .active_o(active_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       tag;
        logic [31:0] pc, pc4, baddr, alu, hi, lo, npc, nhi, nlo;
        logic        br, act;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc, m_hi, m_lo;
    logic        m_active;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural meaning of each op.
    function automatic exp_t model(input string tag, input logic [5:0] op, input logic [5:0] fn,
                                   input logic [4:0] sh, input logic [4:0] rtf,
                                   input logic [15:0] imm, input logic [25:0] idx,
                                   input logic [31:0] rs, input logic [31:0] rt);
        exp_t        e;
        longint      srs, srt, simm, q, r;
        logic [63:0] p;
        bit          jreg;
        srs  = longint'($signed(rs));
        srt  = longint'($signed(rt));
        simm = longint'($signed(imm));
        e.tag = tag;
        e.pc = m_pc; e.hi = m_hi; e.lo = m_lo; e.act = m_active;
        e.pc4   = m_pc + 32'd4;
        e.baddr = 32'(longint'(e.pc4) + simm * 4);
        e.alu = 0; e.br = 0; e.nhi = m_hi; e.nlo = m_lo;
        jreg = 0;
        case (op)
            6'h00: case (fn)
                6'h00: e.alu = rt << sh;
                6'h02: e.alu = rt >> sh;
                6'h03: e.alu = 32'(srt >>> sh);
                6'h04: e.alu = rt << rs[4:0];
                6'h06: e.alu = rt >> rs[4:0];
                6'h07: e.alu = 32'(srt >>> rs[4:0]);
                6'h08: jreg = 1;
                6'h09: begin jreg = 1; e.alu = m_pc + 32'd8; end
                6'h10: e.alu = m_hi;
                6'h12: e.alu = m_lo;
                6'h11: e.nhi = rs;
                6'h13: e.nlo = rs;
                6'h18: begin p = 64'(srs * srt); e.nhi = p[63:32]; e.nlo = p[31:0]; end
                6'h19: begin p = 64'(rs) * 64'(rt); e.nhi = p[63:32]; e.nlo = p[31:0]; end
                6'h1A: if (rt != 0) begin q = srs / srt; r = srs % srt; e.nlo = 32'(q); e.nhi = 32'(r); end
                6'h1B: if (rt != 0) begin e.nlo = rs / rt; e.nhi = rs % rt; end
                6'h20, 6'h21: e.alu = 32'(srs + srt);
                6'h22, 6'h23: e.alu = 32'(srs - srt);
                6'h24: e.alu = rs & rt;
                6'h25: e.alu = rs | rt;
                6'h26: e.alu = rs ^ rt;
                6'h27: e.alu = ~(rs | rt);
                6'h2A: e.alu = (srs < srt) ? 1 : 0;
                6'h2B: e.alu = (longint'(rs) < longint'(rt)) ? 1 : 0;
                default: ;
            endcase
            6'h01: begin
                if (rtf == 5'h00 || rtf == 5'h10) e.br = (srs < 0);
                if (rtf == 5'h01 || rtf == 5'h11) e.br = (srs >= 0);
                if (rtf == 5'h10 || rtf == 5'h11) e.alu = m_pc + 32'd8;
            end
            6'h03: e.alu = m_pc + 32'd8;
            6'h04: e.br = (rs == rt);
            6'h05: e.br = (rs != rt);
            6'h06: e.br = (srs <= 0);
            6'h07: e.br = (srs > 0);
            6'h08, 6'h09, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
            6'h28, 6'h29, 6'h2B: e.alu = 32'(srs + simm);
            6'h0A: e.alu = (srs < simm) ? 1 : 0;
            6'h0B: e.alu = (longint'(rs) < longint'(32'(simm) & 64'hFFFF_FFFF)) ? 1 : 0;
            6'h0C: e.alu = rs & 32'(imm);
            6'h0D: e.alu = rs | 32'(imm);
            6'h0E: e.alu = rs ^ 32'(imm);
            6'h0F: e.alu = 32'(imm) * 32'h10000;
            default: ;
        endcase
        if (jreg)                         e.npc = rs;
        else if (op == 6'h02 || op == 6'h03) e.npc = {e.pc4[31:28], idx, 2'b00};
        else if (e.br)                    e.npc = e.baddr;
        else                              e.npc = e.pc4;
        return e;
    endfunction

    task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] sh, input logic [4:0] rtf, input logic [15:0] imm,
                        input logic [25:0] idx, input logic [31:0] rs, input logic [31:0] rt,
                        input logic ce);
        exp_t e;
        opcode_i = op; functcode_i = fn; shamt_i = sh; rt_field_i = rtf;
        immediate_i = imm; instr_index_i = idx; rs_content_i = rs; rt_content_i = rt;
        clk_enable_i = ce;
        e = model(tag, op, fn, sh, rtf, imm, idx, rs, rt);
        sb.push_back(e);
        @(posedge clk_i); #1;
        if (!reset_i && ce && m_active) begin
            m_pc = e.npc; m_hi = e.nhi; m_lo = e.nlo;
            if (e.npc == 32'd0) m_active = 1'b0;
        end
    endtask

    task automatic rtype(input string tag, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] rs, input logic [31:0] rt);
        step(tag, 6'h00, fn, sh, 5'd0, 16'h0, 26'h0, rs, rt, 1'b1);
    endtask

    task automatic itype(input string tag, input logic [5:0] op, input logic [15:0] imm,
                         input logic [31:0] rs, input logic [31:0] rt);
        step(tag, op, 6'h00, 5'd0, 5'd0, imm, 26'h0, rs, rt, 1'b1);
    endtask

    // Asynchronous: asserted mid-cycle, observed at the next negedge before any posedge.
    task automatic do_reset();
        reset_i = 1'b1;
        m_pc = 32'hBFC0_0000; m_hi = 0; m_lo = 0; m_active = 1'b1;
        itype("reset", 6'h09, 16'h0010, 32'h1234, 32'h0);
        reset_i = 1'b0;
    endtask

    always @(negedge clk_i) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, ".pc"},     pc_o,             e.pc);
            chk({e.tag, ".pc4"},    pc_plus4_o,       e.pc4);
            chk({e.tag, ".baddr"},  branch_address_o, e.baddr);
            chk({e.tag, ".alu"},    alu_result_o,     e.alu);
            chk({e.tag, ".br"},     {31'd0, sig_branch_o}, {31'd0, e.br});
            chk({e.tag, ".hi"},     hi_o,             e.hi);
            chk({e.tag, ".lo"},     lo_o,             e.lo);
            chk({e.tag, ".active"}, {31'd0, active_o}, {31'd0, e.act});
        end
    end

    logic [5:0] ops[] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                          6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h23,
                          6'h2B, 6'h3F};
    logic [5:0] fns[] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09, 6'h10, 6'h11,
                          6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20, 6'h21, 6'h22, 6'h23,
                          6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h3E};
    logic [4:0] rtfs[] = '{5'h00, 5'h01, 5'h10, 5'h11, 5'h05};

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 3))
            0: return $urandom_range(0, 16);
            1: return 32'hFFFF_FFFF - $urandom_range(0, 16);
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset_i = 1'b0; clk_enable_i = 1'b1;
        opcode_i = 0; functcode_i = 0; shamt_i = 0; rt_field_i = 0;
        immediate_i = 0; instr_index_i = 0; rs_content_i = 0; rt_content_i = 0;
        m_pc = 32'hBFC0_0000; m_hi = 0; m_lo = 0; m_active = 1'b1;
        @(posedge clk_i); #1;
        do_reset();

        itype("addiu", 6'h09, 16'hFFFF, 32'd5, 32'd0);
        do_reset();
        itype("beq_t", 6'h04, 16'h0003, 32'd7, 32'd7);
        do_reset();
        itype("beq_nt", 6'h04, 16'h0003, 32'd7, 32'd8);

        rtype("mult", 6'h18, 5'd0, 32'hFFFF_FFFE, 32'd3);
        rtype("mfhi", 6'h10, 5'd0, 32'd0, 32'd0);
        rtype("mflo", 6'h12, 5'd0, 32'd0, 32'd0);
        rtype("div", 6'h1A, 5'd0, 32'hFFFF_FFF9, 32'd2);
        rtype("divu0", 6'h1B, 5'd0, 32'd99, 32'd0);
        rtype("mfhi2", 6'h10, 5'd0, 32'd0, 32'd0);
        rtype("div_ovf", 6'h1A, 5'd0, 32'h8000_0000, 32'hFFFF_FFFF);
        rtype("sra", 6'h03, 5'd4, 32'd0, 32'h8000_0000);
        rtype("sltu", 6'h2B, 5'd0, 32'd1, 32'hFFFF_FFFF);
        rtype("slt", 6'h2A, 5'd0, 32'd1, 32'hFFFF_FFFF);
        itype("lui", 6'h0F, 16'h1234, 32'd0, 32'd0);
        itype("bltzal", 6'h01, 16'hFFFE, 32'hFFFF_FFFF, 32'd0);

        rtype("mthi", 6'h11, 5'd0, 32'hCAFE_0001, 32'd0);
        for (int i = 0; i < 3; i++)
            step("ce0", 6'h09, 6'h00, 5'd0, 5'd0, 16'h0004, 26'h0, 32'd1, 32'd0, 1'b0);

        do_reset();
        step("jal", 6'h03, 6'h00, 5'd0, 5'd0, 16'h0, 26'h2AB_CDEF, 32'd0, 32'd0, 1'b1);

        do_reset();
        rtype("jr0", 6'h08, 5'd0, 32'd0, 32'd0);
        rtype("halted", 6'h18, 5'd0, 32'd3, 32'd3);
        itype("halted2", 6'h09, 16'h0004, 32'd8, 32'd0);
        do_reset();

        for (int i = 0; i < 600; i++) begin
            logic [5:0] op;
            if (i % 97 == 96) do_reset();
            op = ops[$urandom_range(0, ops.size() - 1)];
            step("rand", op, fns[$urandom_range(0, fns.size() - 1)], 5'($urandom),
                 rtfs[$urandom_range(0, rtfs.size() - 1)], 16'($urandom), 26'($urandom),
                 rand_val(), rand_val(), ($urandom_range(0, 7) != 0));
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk_i);
        chk("drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_branch_pc.md
# alu_branch_pc

Execute-and-fetch-control slice of the single-cycle Harvard MIPS CPU. It holds the program counter, the HI/LO registers and the active flag. It also contains the main ALU and the branch-target adder. From decoded instruction fields and register-file contents it combinationally produces the ALU result (data address / writeback value), the branch decision and the next PC, which is committed on the clock edge.

## Interface
- No parameters. Reset vector is fixed at 0xBFC00000.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- clk_enable  in  1  when 0, PC, HI, LO and active hold their values.
- opcode  in  6  instr[31:26].
- functcode  in  6  instr[5:0].
- shamt  in  5  instr[10:6].
- rt_field  in  5  instr[20:16]; selects the REGIMM branch type.
- immediate  in  16  instr[15:0].
- instr_index  in  26  instr[25:0]; J/JAL target.
- rs_content, rt_content  in  32 each  register-file read data.
- pc  out  32  current PC, i.e. instr_address.
- pc_plus4  out  32  pc + 4.
- branch_address  out  32  pc_plus4 + (sign_extend(immediate) << 2).
- alu_result  out  32  ALU output, also used as data_address.
- sig_branch  out  1  conditional branch taken.
- hi, lo  out  32 each  HI/LO register contents.
- active  out  1  CPU running.

## Operation
- All arithmetic is 32-bit modulo 2^32. No overflow traps; ADD/ADDI/SUB behave as ADDU/ADDIU/SUBU.
- Unlisted opcode/funct combinations: alu_result = 0, sig_branch = 0, no HI/LO write.

R-type (opcode 0x00), by funct:
- SLL 0x00, SRL 0x02, SRA 0x03: shift rt by shamt.
- SLLV 0x04, SRLV 0x06, SRAV 0x07: shift rt by rs[4:0].
- JR 0x08: alu_result = 0.
- JALR 0x09: alu_result = pc + 8.
- MFHI 0x10 / MFLO 0x12: alu_result = hi / lo.
- MTHI 0x11 / MTLO 0x13: write rs into HI / LO.
- MULT 0x18 / MULTU 0x19: 64-bit signed/unsigned product; {HI,LO} ← product.
- DIV 0x1A / DIVU 0x1B: LO ← quotient, HI ← remainder. Signed division truncates toward zero. Divisor 0 leaves HI/LO unchanged.
- ADD/ADDU 0x20/0x21: rs + rt. SUB/SUBU 0x22/0x23: rs − rt.
- AND 0x24, OR 0x25, XOR 0x26, NOR 0x27: bitwise.
- SLT 0x2A / SLTU 0x2B: result is 1 or 0, signed / unsigned compare.

I-type:
- ADDI/ADDIU 0x08/0x09: rs + sext(imm).
- SLTI 0x0A / SLTIU 0x0B: compare rs against sext(imm), signed / unsigned.
- ANDI 0x0C, ORI 0x0D, XORI 0x0E: use zext(imm).
- LUI 0x0F: imm << 16.
- Loads/stores 0x20–0x26, 0x28, 0x29, 0x2B: alu_result = rs + sext(imm).
- JAL 0x03: alu_result = pc + 8.

Branches (sig_branch = 1 when the condition holds):
- BEQ 0x04: rs == rt. BNE 0x05: rs != rt.
- BLEZ 0x06: signed rs ≤ 0. BGTZ 0x07: signed rs > 0.
- REGIMM 0x01, by rt_field: BLTZ 0x00 / BLTZAL 0x10 taken when rs < 0; BGEZ 0x01 / BGEZAL 0x11 taken when rs ≥ 0.
- For the AL variants, alu_result = pc + 8 regardless of the condition.

Next-PC priority (no delay slot):
1. JR/JALR: rs_content.
2. J (0x02) / JAL (0x03): {pc_plus4[31:28], instr_index, 2'b00}.
3. sig_branch: branch_address.
4. Otherwise: pc_plus4.

## Timing
- While reset is high (asynchronous): pc = 0xBFC00000, hi = 0, lo = 0, active = 1. All outputs are valid combinationally from the reset state.
- alu_result, sig_branch, branch_address, pc_plus4 and the next-PC value are purely combinational from the inputs and current state, with zero latency.
- On each rising clk with clk_enable = 1 and active = 1:
  - pc ← next-PC.
  - HI/LO are written per the instruction.
- If the new pc equals 0x00000000, active ← 0 on the same edge.
- With active = 0, pc, HI and LO hold until the next reset.
- With clk_enable = 0, all state holds, even if an edge occurs.
- Reset asserted mid-operation overrides any pending update immediately.

## Test plan
- Reset then release: pc = 0xBFC00000, active = 1, hi = lo = 0. With opcode ADDIU, rs = 5, imm = 0xFFFF, alu_result = 4; after one edge pc = 0xBFC00004.
- BEQ with rs = rt = 7, imm = 0x0003 at pc 0xBFC00000: sig_branch = 1, branch_address = 0xBFC00010; pc = 0xBFC00010 after the edge. Repeat with rt = 8: sig_branch = 0, pc = 0xBFC00004.
- MULT rs = 0xFFFFFFFE (−2), rt = 3, then MFHI and MFLO: hi = 0xFFFFFFFF, lo = 0xFFFFFFFA. DIV rs = −7, rt = 2: lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU with rt = 0: HI/LO unchanged.
- SRA rt = 0x80000000, shamt = 4 → 0xF8000000. SLTU rs = 1, rt = 0xFFFFFFFF → 1. SLT on the same operands → 0. LUI imm = 0x1234 → 0x12340000.
- JR with rs = 0: pc = 0 after the edge and active falls to 0. Further edges leave pc = 0; asserting reset restores 0xBFC00000 and active = 1.
- clk_enable = 0 for 3 edges during an ADDIU: pc and HI/LO unchanged. JAL at pc 0xBFC00000: alu_result = 0xBFC00008, and the jump target is formed from pc_plus4[31:28].
